block_sync: RTL

Word-boundary lock stage between the GT receive gearbox and the descrambler. It examines the 2-bit sync header of each received 67-bit block and pulses a gearbox slip until the block boundary is found. It declares lock after a run of legal headers and drops lock when too many illegal headers appear in a monitoring window. `BLOCK_LOCK` gates the downstream descrambler: its `PASSTHROUGH` input is driven by `~BLOCK_LOCK`.

---
 rtl/block_sync.sv | 139 +++++++++++++
 1 files changed

// File: rtl/block_sync.sv
// block_sync: word-boundary lock for 67-bit blocks. Slips the RX gearbox on illegal sync
// headers until a run of legal headers is seen, then watches header quality window by window.
module block_sync #(
  parameter int SH_CNT_MAX         = 64,
  parameter int SH_INVALID_CNT_MAX = 16,
  parameter int SLIP_WAIT_CYCLES   = 32
) (
  input  logic       USER_CLK,
  input  logic       SYSTEM_RESET,
  input  logic [1:0] HEADER_IN,
  input  logic       HEADER_VALID_IN,
  output logic       RXGEARBOX_SLIP,
  output logic       BLOCK_LOCK
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int WAIT_W = (SLIP_WAIT_CYCLES > 0) ? $clog2(SLIP_WAIT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  SH_CNT_LIMIT  = CNT_W'(SH_CNT_MAX);
  localparam logic [CNT_W-1:0]  INV_CNT_LIMIT = CNT_W'(SH_INVALID_CNT_MAX);
  localparam logic [CNT_W-1:0]  CNT_ZERO      = '0;
  localparam logic [WAIT_W-1:0] WAIT_LOAD     = WAIT_W'(SLIP_WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_ONE      = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO     = '0;

  localparam logic [1:0] TEST_SH   = 2'd0;
  localparam logic [1:0] SLIP_WAIT = 2'd1;
  localparam logic [1:0] LOCKED    = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  sh_cnt_reg, sh_cnt_next;
  logic [CNT_W-1:0]  sh_invalid_cnt_reg, sh_invalid_cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              block_lock_reg, block_lock_next;
  logic              slip_reg, slip_next;

  logic              header_legal;
  logic [CNT_W-1:0]  sh_cnt_inc;
  logic [CNT_W-1:0]  sh_invalid_cnt_inc;

  // A legal sync header has exactly one bit set (01 = data, 10 = control).
  assign header_legal       = HEADER_IN[1] ^ HEADER_IN[0];
  assign sh_cnt_inc         = sh_cnt_reg + CNT_W'(1);
  assign sh_invalid_cnt_inc = sh_invalid_cnt_reg + CNT_W'(!header_legal);

  always_comb begin
    state_next          = state_reg;
    sh_cnt_next         = sh_cnt_reg;
    sh_invalid_cnt_next = sh_invalid_cnt_reg;
    wait_cnt_next       = wait_cnt_reg;
    block_lock_next     = block_lock_reg;
    slip_next           = 1'b0;

    case (state_reg)
      TEST_SH: begin
        if (HEADER_VALID_IN) begin
          if (header_legal) begin
            if (sh_cnt_inc == SH_CNT_LIMIT) begin
              state_next          = LOCKED;
              block_lock_next     = 1'b1;
              sh_cnt_next         = CNT_ZERO;
              sh_invalid_cnt_next = CNT_ZERO;
            end else begin
              sh_cnt_next = sh_cnt_inc;
            end
          end else begin
            state_next          = SLIP_WAIT;
            slip_next           = 1'b1;
            sh_cnt_next         = CNT_ZERO;
            sh_invalid_cnt_next = CNT_ZERO;
            wait_cnt_next       = WAIT_LOAD;
          end
        end
      end

      SLIP_WAIT: begin
        // Countdown runs regardless of HEADER_VALID_IN; the gearbox settles in wall-clock cycles.
        if (wait_cnt_reg <= WAIT_ONE) begin
          state_next          = TEST_SH;
          wait_cnt_next       = WAIT_ZERO;
          sh_cnt_next         = CNT_ZERO;
          sh_invalid_cnt_next = CNT_ZERO;
        end else begin
          wait_cnt_next = wait_cnt_reg - WAIT_ONE;
        end
      end

      LOCKED: begin
        if (HEADER_VALID_IN) begin
          // Invalid-count limit is tested first so it wins over a coincident window end.
          if (sh_invalid_cnt_inc == INV_CNT_LIMIT) begin
            state_next          = SLIP_WAIT;
            block_lock_next     = 1'b0;
            slip_next           = 1'b1;
            sh_cnt_next         = CNT_ZERO;
            sh_invalid_cnt_next = CNT_ZERO;
            wait_cnt_next       = WAIT_LOAD;
          end else if (sh_cnt_inc == SH_CNT_LIMIT) begin
            sh_cnt_next         = CNT_ZERO;
            sh_invalid_cnt_next = CNT_ZERO;
          end else begin
            sh_cnt_next         = sh_cnt_inc;
            sh_invalid_cnt_next = sh_invalid_cnt_inc;
          end
        end
      end

      default: begin
        state_next          = TEST_SH;
        block_lock_next     = 1'b0;
        sh_cnt_next         = CNT_ZERO;
        sh_invalid_cnt_next = CNT_ZERO;
        wait_cnt_next       = WAIT_ZERO;
      end
    endcase
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      state_reg          <= TEST_SH;
      sh_cnt_reg         <= CNT_ZERO;
      sh_invalid_cnt_reg <= CNT_ZERO;
      wait_cnt_reg       <= WAIT_ZERO;
      block_lock_reg     <= 1'b0;
      slip_reg           <= 1'b0;
    end else begin
      state_reg          <= state_next;
      sh_cnt_reg         <= sh_cnt_next;
      sh_invalid_cnt_reg <= sh_invalid_cnt_next;
      wait_cnt_reg       <= wait_cnt_next;
      block_lock_reg     <= block_lock_next;
      slip_reg           <= slip_next;
    end
  end

  assign RXGEARBOX_SLIP = slip_reg;
  assign BLOCK_LOCK     = block_lock_reg;

endmodule
